proc_multi_timer: RTL and testbench

// - Parametrised interval timer: NUM_CH independent down-counters on one Avalon-MM slave, shared prescaler.
// - Per-channel periodic/one-shot, per-channel IRQ plus OR-combined IRQ line.
// - Sits on the per-processor system bus; gives each NIOS core several timebases from one peripheral.

---
 rtl/proc_timer_pkg.sv | 26 ++
 rtl/proc_timer_channel.sv | 99 +++++++++
 rtl/proc_multi_timer.sv | 117 +++++++++++
 tb/tb_proc_multi_timer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Imported by the channel sub-module and the bus-facing top level.
package proc_timer_pkg;

  // Register offset inside one channel's four-word window.
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_e;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Prescaler counter width; at least one bit so the vector is always legal.
  function automatic int prescale_width(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/proc_timer_channel.sv
// One timer channel: down-counter, RUN/TO flags, CONTROL, PERIOD and SNAP.
// Driven by the shared tick and by write strobes already decoded by the top.
module proc_timer_channel
  import proc_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [CNT_W-1:0] wdata,
  output logic [1:0]       status,
  output logic [1:0]       control,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             irq
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0] count;
  logic             run;
  logic             to;
  logic             ito;
  logic             cont;
  logic             force_reload;
  logic             was_nz;

  logic start;
  logic stop;
  logic at_zero;
  logic timeout;
  logic wrap;

  assign start   = wr_control & wdata[CTRL_START];
  assign stop    = wr_control & wdata[CTRL_STOP];
  assign at_zero = (count == '0);
  // Edge-detect on reaching zero so a PERIOD of 0 fires once, not every tick.
  assign timeout = at_zero & was_nz;
  assign wrap    = run & tick & at_zero;

  // NOTE: every register here, PERIOD included, is an individual flop with an
  // explicit reset value; sequential state is assigned only with <= so all
  // flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= RST_CNT;
      period       <= RST_CNT;
      snap         <= '0;
      run          <= 1'b0;
      to           <= 1'b0;
      ito          <= 1'b0;
      cont         <= 1'b0;
      force_reload <= 1'b0;
      was_nz       <= (RST_CNT != '0);
    end else begin
      force_reload <= wr_period;
      was_nz       <= ~at_zero;

      if (wr_period)  period      <= wdata;
      if (wr_control) {cont, ito} <= {wdata[CTRL_CONT], wdata[CTRL_ITO]};
      if (wr_snap)    snap        <= count;

      // A timeout in the same cycle as a STATUS write must not be lost.
      if (timeout)        to <= 1'b1;
      else if (wr_status) to <= 1'b0;

      if (force_reload) begin
        count <= period;
        run   <= 1'b0;
      end else begin
        if (run && tick) count <= at_zero ? period : count - 1'b1;

        if (start)             run <= 1'b1;
        else if (stop)         run <= 1'b0;
        else if (wrap && !cont) run <= 1'b0;
      end
    end
  end

  // NOTE: combinational blocks assign a default to every output first, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    status           = '0;
    status[STAT_TO]  = to;
    status[STAT_RUN] = run;
    control                = '0;
    control[CTRL_ITO]      = ito;
    control[CTRL_CONT]     = cont;
  end

  assign irq = to & ito;

endmodule

// File: rtl/proc_multi_timer.sv
// Avalon-MM interval timer with NUM_CH independent channels and a shared
// prescaler; address is {channel, reg[1:0]}, read data is registered.
module proc_multi_timer
  import proc_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int DATA_W     = 32,
  parameter int PRESCALE   = 1,
  parameter int RST_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [DATA_W-1:0]         writedata,
  output logic [DATA_W-1:0]         readdata,
  output logic [NUM_CH-1:0]         irq,
  output logic                      irq_any
);

  localparam int AW   = $clog2(NUM_CH) + 2;
  localparam int CH_W = AW - 1;

  // Padding with a zero MSB keeps the channel field at least one bit wide,
  // which also makes a single-channel build decode cleanly.
  logic [AW:0]     addr_ext;
  logic [CH_W-1:0] ch_idx;
  reg_e            reg_sel;
  logic            wr_hit;
  logic            rd_hit;
  logic            tick;

  assign addr_ext = {1'b0, address};
  assign ch_idx   = addr_ext[AW:2];
  assign reg_sel  = reg_e'(addr_ext[1:0]);
  assign wr_hit   = chipselect & ~write_n;
  assign rd_hit   = chipselect &  write_n;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int PW = prescale_width(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre;

      // Free-running and never restarted by START, so first-tick phase varies.
      always_ff @(posedge clk) begin
        if (reset)               pre <= '0;
        else if (pre == PRE_LAST) pre <= '0;
        else                     pre <= pre + 1'b1;
      end

      assign tick = (pre == PRE_LAST);
    end
  endgenerate

  logic [1:0]       status_rd  [NUM_CH];
  logic [1:0]       control_rd [NUM_CH];
  logic [CNT_W-1:0] period_rd  [NUM_CH];
  logic [CNT_W-1:0] snap_rd    [NUM_CH];

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic sel;
      assign sel = wr_hit && (ch_idx == CH_W'(g));

      proc_timer_channel #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD)
      ) u_channel (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .wr_status  (sel && (reg_sel == REG_STATUS)),
        .wr_control (sel && (reg_sel == REG_CONTROL)),
        .wr_period  (sel && (reg_sel == REG_PERIOD)),
        .wr_snap    (sel && (reg_sel == REG_SNAP)),
        .wdata      (writedata[CNT_W-1:0]),
        .status     (status_rd[g]),
        .control    (control_rd[g]),
        .period     (period_rd[g]),
        .snap       (snap_rd[g]),
        .irq        (irq[g])
      );
    end
  endgenerate

  assign irq_any = |irq;

  // Channel indices beyond NUM_CH match nothing and read back as zero.
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) begin
        case (reg_sel)
          REG_STATUS:  rd_mux = DATA_W'(status_rd[i]);
          REG_CONTROL: rd_mux = DATA_W'(control_rd[i]);
          REG_PERIOD:  rd_mux = DATA_W'(period_rd[i]);
          REG_SNAP:    rd_mux = DATA_W'(snap_rd[i]);
          default:     rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       readdata <= '0;
    else if (rd_hit) readdata <= rd_mux;
    else             readdata <= '0;
  end

endmodule

// File: tb/tb_proc_multi_timer.sv
// Directed bench for proc_multi_timer: instance A (4 channels, PRESCALE=1) and
// instance B (3 channels, PRESCALE=4) share the bus but have separate selects.
module tb_proc_multi_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [3:0]  irq_a;
  logic [2:0]  irq_b;
  logic        any_a;
  logic        any_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proc_multi_timer #(
    .NUM_CH(4), .CNT_W(32), .DATA_W(32), .PRESCALE(1), .RST_PERIOD(49999)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .irq(irq_a), .irq_any(any_a)
  );

  proc_multi_timer #(
    .NUM_CH(3), .CNT_W(32), .DATA_W(32), .PRESCALE(4), .RST_PERIOD(49999)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .irq(irq_b), .irq_any(any_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // NOTE: bench stimulus uses blocking assignments, applied on the falling
  // edge so the DUT samples settled values on the rising edge.
  task automatic bus_write(input bit to_b, input int ch, input int rg, input logic [31:0] d);
    address   = 4'(ch * 4 + rg);
    cs_a      = ~to_b;
    cs_b      = to_b;
    write_n   = 1'b0;
    writedata = d;
    @(negedge clk);
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  task automatic bus_read(input bit to_b, input int ch, input int rg, output logic [31:0] d);
    address = 4'(ch * 4 + rg);
    cs_a    = ~to_b;
    cs_b    = to_b;
    write_n = 1'b1;
    @(negedge clk);
    d    = to_b ? rd_b : rd_a;
    cs_a = 1'b0;
    cs_b = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_irq(input bit to_b, input int b, input string tag, output int stamp);
    bit found = 1'b0;
    stamp = cyc;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (to_b ? irq_b[b] : irq_a[b]) begin
        found = 1'b1;
        stamp = cyc;
      end
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int s, r1, r2, r3, rises;

    reset = 1'b1; address = '0; cs_a = 1'b0; cs_b = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_irq_a", 32'(irq_a), 32'd0);
    check("rst_irq_any_a", 32'(any_a), 32'd0);
    check("rst_irq_b", 32'(irq_b), 32'd0);
    @(negedge clk);
    check("rst_readdata", rd_a, 32'd0);

    // Reset read-back of every register on instance A.
    for (int ch = 0; ch < 4; ch++) begin
      for (int rg = 0; rg < 4; rg++) begin
        bus_read(1'b0, ch, rg, d);
        check($sformatf("rst_ch%0d_reg%0d", ch, rg), d, (rg == 2) ? 32'd49999 : 32'd0);
      end
    end

    // CONTROL keeps only ITO/CONT; high bits and strobes read back as 0.
    bus_write(1'b0, 1, 1, 32'hFFFF_FFF3);
    bus_read(1'b0, 1, 1, d);
    check("ctrl_mask", d, 32'd3);
    bus_write(1'b0, 1, 1, 32'd0);
    bus_read(1'b0, 1, 0, d);
    check("ctrl_no_start", d, 32'd0);

    // Instance B has 3 channels: channel 3 ignores writes and reads 0.
    bus_write(1'b1, 3, 2, 32'h1234);
    bus_read(1'b1, 3, 2, d);
    check("nochan_period", d, 32'd0);
    bus_read(1'b1, 1, 2, d);
    check("b_rst_period", d, 32'd49999);

    // ch2 periodic: PERIOD=5, ITO|CONT|START.
    bus_write(1'b0, 2, 2, 32'd5);
    @(negedge clk);
    bus_write(1'b0, 2, 1, 32'h7);
    s = cyc;
    wait_irq(1'b0, 2, "ch2_first", r1);
    check("ch2_first_latency", 32'(r1 - s), 32'd6);
    check("ch2_irq_vec", 32'(irq_a), 32'h4);
    check("ch2_irq_any", 32'(any_a), 32'd1);
    bus_write(1'b0, 2, 0, 32'd0);
    check("ch2_to_cleared", 32'(irq_a[2]), 32'd0);
    check("ch2_any_cleared", 32'(any_a), 32'd0);
    wait_irq(1'b0, 2, "ch2_second", r2);
    check("ch2_interval", 32'(r2 - r1), 32'd6);
    bus_write(1'b0, 2, 0, 32'd0);
    wait_until(r2 + 5);
    // This STATUS write lands on the same edge as the next timeout.
    bus_write(1'b0, 2, 0, 32'd0);
    check("collide_irq", 32'(irq_a[2]), 32'd1);
    check("collide_any", 32'(any_a), 32'd1);
    bus_read(1'b0, 2, 0, d);
    check("collide_status", d, 32'd3);
    bus_write(1'b0, 2, 1, 32'h8);
    bus_write(1'b0, 2, 0, 32'd0);
    bus_read(1'b0, 2, 0, d);
    check("ch2_stopped_status", d, 32'd0);

    // ch0 one-shot: PERIOD=3, ITO|START.
    bus_write(1'b0, 0, 2, 32'd3);
    @(negedge clk);
    bus_write(1'b0, 0, 1, 32'h5);
    s = cyc;
    wait_irq(1'b0, 0, "ch0_oneshot", r1);
    check("ch0_latency", 32'(r1 - s), 32'd4);
    bus_read(1'b0, 0, 0, d);
    check("ch0_status_after", d, 32'd1);
    bus_write(1'b0, 0, 3, 32'd0);
    bus_read(1'b0, 0, 3, d);
    check("ch0_reloaded", d, 32'd3);
    bus_write(1'b0, 0, 0, 32'd0);
    rises = 0;
    repeat (20) begin
      @(negedge clk);
      if (irq_a[0]) rises++;
    end
    check("ch0_no_second", 32'(rises), 32'd0);

    // Instance B ch1 with PRESCALE=4: PERIOD=2, ITO|CONT|START.
    bus_write(1'b1, 1, 2, 32'd2);
    @(negedge clk);
    bus_write(1'b1, 1, 1, 32'h7);
    wait_irq(1'b1, 1, "b_first", r1);
    check("b_irq_vec", 32'(irq_b), 32'h2);
    check("b_irq_any", 32'(any_b), 32'd1);
    bus_write(1'b1, 1, 0, 32'd0);
    wait_until(r1 + 5);
    bus_write(1'b1, 1, 3, 32'd0);
    bus_read(1'b1, 1, 3, d);
    check("b_snap_after_reload", d, 32'd2);
    wait_until(r1 + 9);
    bus_write(1'b1, 1, 3, 32'd0);
    bus_read(1'b1, 1, 3, d);
    check("b_snap_one_tick", d, 32'd1);
    wait_irq(1'b1, 1, "b_second", r2);
    check("b_interval", 32'(r2 - r1), 32'd12);

    // ch3 SNAP / STOP / START / PERIOD-write sequence.
    bus_write(1'b0, 3, 2, 32'd100);
    @(negedge clk);
    bus_write(1'b0, 3, 1, 32'h4);
    s = cyc;
    wait_until(s + 9);
    bus_write(1'b0, 3, 3, 32'd0);
    bus_read(1'b0, 3, 3, d);
    check("ch3_snap_run", d, 32'd91);
    bus_write(1'b0, 3, 1, 32'h8);
    bus_write(1'b0, 3, 3, 32'd0);
    bus_read(1'b0, 3, 3, d);
    check("ch3_snap_stop", d, 32'd88);
    repeat (5) @(negedge clk);
    bus_write(1'b0, 3, 3, 32'd0);
    bus_read(1'b0, 3, 3, d);
    check("ch3_hold", d, 32'd88);
    bus_read(1'b0, 3, 0, d);
    check("ch3_status_stopped", d, 32'd0);
    bus_write(1'b0, 3, 1, 32'h4);
    r3 = cyc;
    wait_until(r3 + 2);
    bus_write(1'b0, 3, 3, 32'd0);
    bus_read(1'b0, 3, 3, d);
    check("ch3_resume", d, 32'd86);
    bus_read(1'b0, 3, 0, d);
    check("ch3_status_running", d, 32'd2);
    bus_write(1'b0, 3, 2, 32'd50);
    @(negedge clk);
    bus_read(1'b0, 3, 0, d);
    check("ch3_period_stops", d, 32'd0);
    bus_write(1'b0, 3, 3, 32'd0);
    bus_read(1'b0, 3, 3, d);
    check("ch3_period_reload", d, 32'd50);

    // Reset while counting with an interrupt pending.
    bus_write(1'b0, 1, 2, 32'd2);
    @(negedge clk);
    bus_write(1'b0, 1, 1, 32'h7);
    wait_irq(1'b0, 1, "ch1_pre_reset", r1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_irq_a", 32'(irq_a), 32'd0);
    check("midrst_any_a", 32'(any_a), 32'd0);
    check("midrst_irq_b", 32'(irq_b), 32'd0);
    check("midrst_readdata", rd_a, 32'd0);
    bus_read(1'b0, 1, 2, d);
    check("midrst_period", d, 32'd49999);
    bus_read(1'b0, 1, 0, d);
    check("midrst_status", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
